// File: rtl/imem_boot_ctrl.sv
// Boot controller sharing the instruction memory port between loader and fetch.
// Ports: clk/reset, loader valid/ready stream, core fetch, memory port, status.
module imem_boot_ctrl #(
  parameter int DEPTH = 64,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic [31:0]   load_data,
  input  logic          load_last,
  output logic          load_ready,
  input  logic [31:0]   cpu_pc,
  output logic [31:0]   cpu_instr,
  output logic          cpu_run,
  output logic          core_reset,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_we,
  input  logic [31:0]   mem_rdata,
  output logic [CW-1:0] words_loaded,
  output logic          load_overflow,
  output logic          pc_fault
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RELEASE,
    RUN,
    HALT
  } state_t;

  state_t state;
  state_t state_d;

  logic [AW-1:0] wa;
  logic          we_q;
  logic [31:0]   wdata_q;
  logic [CW-1:0] wl;
  logic          ovf_q;
  logic          flt_q;

  logic          acc;
  logic          clr;
  logic          set_ovf;
  logic          set_flt;
  logic          fault;
  logic          at_cap;
  logic [CW-1:0] cnt;
  logic [31:0]   wa_addr;

  // Words accepted so far, counting one still waiting in the write stage.
  assign cnt     = wl + CW'(we_q);
  assign at_cap  = (cnt == CW'(DEPTH - 1));
  assign fault   = (cpu_pc[1:0] != 2'b00) | (|cpu_pc[31:AW+2]);
  assign wa_addr = {{(30 - AW){1'b0}}, wa, 2'b00};

  assign mem_we        = we_q;
  assign mem_wdata     = wdata_q;
  assign words_loaded  = wl;
  assign load_overflow = ovf_q;
  assign pc_fault      = flt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d    = state;
    load_ready = 1'b0;
    acc        = 1'b0;
    clr        = 1'b0;
    set_ovf    = 1'b0;
    set_flt    = 1'b0;
    core_reset = 1'b1;
    cpu_run    = 1'b0;
    cpu_instr  = 32'h0;
    mem_addr   = wa_addr;
    unique case (state)
      IDLE: begin
        if (load_start) begin
          state_d = LOAD;
          clr     = 1'b1;
        end
      end
      LOAD: begin
        load_ready = ~load_start;
        acc        = load_valid & ~load_start;
        if (load_start) begin
          clr = 1'b1;
        end else if (acc) begin
          if (load_last | at_cap) begin
            state_d = RELEASE;
          end
          set_ovf = ~load_last & at_cap;
        end
      end
      RELEASE: begin
        state_d = RUN;
      end
      RUN: begin
        core_reset = 1'b0;
        cpu_run    = 1'b1;
        mem_addr   = cpu_pc;
        cpu_instr  = fault ? 32'h0 : mem_rdata;
        // A reload wins over a fault seen in the same cycle.
        if (load_start) begin
          state_d = LOAD;
          clr     = 1'b1;
        end else if (fault) begin
          state_d = HALT;
          set_flt = 1'b1;
        end
      end
      HALT: begin
        core_reset = 1'b0;
        mem_addr   = cpu_pc;
        if (load_start) begin
          state_d = LOAD;
          clr     = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wa      <= '0;
      we_q    <= 1'b0;
      wdata_q <= 32'h0;
      wl      <= '0;
      ovf_q   <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      we_q <= acc;
      if (acc) begin
        wdata_q <= load_data;
      end
      // A restart still lets the pending write finish, but the
      // address and count restart from zero afterwards.
      if (clr) begin
        wa    <= '0;
        wl    <= '0;
        ovf_q <= 1'b0;
        flt_q <= 1'b0;
      end else begin
        if (we_q) begin
          wa <= wa + AW'(1);
          wl <= wl + CW'(1);
        end
        if (set_ovf) begin
          ovf_q <= 1'b1;
        end
        if (set_flt) begin
          flt_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl with a write scoreboard and memory model.
// Instance uses DEPTH=4 so overflow and range faults are reachable.
module tb_imem_boot_ctrl;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_start;
  logic          load_valid;
  logic [31:0]   load_data;
  logic          load_last;
  logic          load_ready;
  logic [31:0]   cpu_pc;
  logic [31:0]   cpu_instr;
  logic          cpu_run;
  logic          core_reset;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic [31:0]   mem_rdata;
  logic [CW-1:0] words_loaded;
  logic          load_overflow;
  logic          pc_fault;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] sb[$];
  logic [31:0] mem[DEPTH];
  logic [31:0] prog[3];
  logic [31:0] ov[5];

  always #5 clk = ~clk;

  imem_boot_ctrl #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_start   (load_start),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_last    (load_last),
    .load_ready   (load_ready),
    .cpu_pc       (cpu_pc),
    .cpu_instr    (cpu_instr),
    .cpu_run      (cpu_run),
    .core_reset   (core_reset),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata),
    .words_loaded (words_loaded),
    .load_overflow(load_overflow),
    .pc_fault     (pc_fault)
  );

  assign mem_rdata = mem[mem_addr[3:2]];

  always @(posedge clk) begin
    if (mem_we === 1'b1) mem[mem_addr[3:2]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Every memory write must match the oldest expected write.
  always @(negedge clk) begin
    logic [63:0] exp;
    if (mem_we === 1'b1) begin
      exp = (sb.size() != 0) ? sb.pop_front() : ~{mem_addr, mem_wdata};
      chk("mem_write", {mem_addr, mem_wdata}, exp);
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    prog[0] = 32'h20080005;
    prog[1] = 32'h20090007;
    prog[2] = 32'h01095020;
    for (int i = 0; i < 5; i++) ov[i] = 32'hA000_0000 + 32'(i);

    reset = 1'b1; load_start = 1'b0; load_valid = 1'b0;
    load_data = 32'h0; load_last = 1'b0; cpu_pc = 32'h0;
    repeat (2) @(posedge clk);
    smp();
    chk("rst_ready", 64'(load_ready), 64'd0);
    chk("rst_run", 64'(cpu_run), 64'd0);
    chk("rst_corerst", 64'(core_reset), 64'd1);
    chk("rst_instr", 64'(cpu_instr), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_words", 64'(words_loaded), 64'd0);
    chk("rst_flags", {62'd0, load_overflow, pc_fault}, 64'd0);

    // Three-word program, valid held high.
    nxt(); reset = 1'b0; load_start = 1'b1;
    smp();
    chk("idle_ready", 64'(load_ready), 64'd0);
    nxt(); load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; load_data = prog[i]; load_last = (i == 2);
      sb.push_back({32'(i * 4), prog[i]});
      smp();
      chk("load_ready", 64'(load_ready), 64'd1);
      chk("load_corerst", 64'(core_reset), 64'd1);
      nxt();
    end
    load_valid = 1'b0; load_last = 1'b0;
    smp();
    chk("rel_corerst", 64'(core_reset), 64'd1);
    chk("rel_run", 64'(cpu_run), 64'd0);
    chk("rel_ready", 64'(load_ready), 64'd0);
    nxt();
    smp();
    chk("run_corerst", 64'(core_reset), 64'd0);
    chk("run_run", 64'(cpu_run), 64'd1);
    chk("run_words", 64'(words_loaded), 64'd3);

    nxt(); cpu_pc = 32'd4;
    smp();
    chk("fetch4_instr", 64'(cpu_instr), 64'h20090007);
    chk("fetch4_addr", 64'(mem_addr), 64'd4);
    chk("fetch4_we", 64'(mem_we), 64'd0);

    // Misaligned PC.
    nxt(); cpu_pc = 32'd6;
    smp();
    chk("mis_instr", 64'(cpu_instr), 64'd0);
    nxt(); cpu_pc = 32'd4;
    smp();
    chk("mis_fault", 64'(pc_fault), 64'd1);
    chk("mis_run", 64'(cpu_run), 64'd0);
    chk("halt_instr", 64'(cpu_instr), 64'd0);
    chk("halt_addr", 64'(mem_addr), 64'd4);
    nxt();
    smp();
    chk("halt_held", {62'd0, cpu_run, pc_fault}, 64'd1);

    // Overflow with gaps in valid; fifth word must be refused.
    nxt(); load_start = 1'b1; cpu_pc = 32'h0;
    nxt(); load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1; load_data = ov[i];
      if (i < 4) sb.push_back({32'(i * 4), ov[i]});
      smp();
      chk("ovf_ready", 64'(load_ready), 64'(i < 4));
      if (i == 0) chk("ovf_fault_clr", 64'(pc_fault), 64'd0);
      if (i == 4) begin
        chk("ovf_words", 64'(words_loaded), 64'd4);
        chk("ovf_run", 64'(cpu_run), 64'd1);
      end
      nxt(); load_valid = 1'b0;
      smp();
      if (i == 3) begin
        chk("ovf_flag", 64'(load_overflow), 64'd1);
        chk("ovf_rel_ready", 64'(load_ready), 64'd0);
        chk("ovf_rel_corerst", 64'(core_reset), 64'd1);
      end
      if (i == 4) chk("ovf_fetch0", 64'(cpu_instr), 64'(ov[0]));
      nxt();
    end

    // Out-of-range PC.
    cpu_pc = 32'(4 * DEPTH);
    smp();
    chk("oor_instr", 64'(cpu_instr), 64'd0);
    chk("oor_addr", 64'(mem_addr), 64'(4 * DEPTH));
    nxt();
    smp();
    chk("oor_fault", {62'd0, cpu_run, pc_fault}, 64'd1);

    // Restart mid-load after two words.
    nxt(); load_start = 1'b1; cpu_pc = 32'h0;
    nxt(); load_start = 1'b0;
    load_valid = 1'b1; load_data = 32'h1111_0000;
    sb.push_back({32'd0, 32'h1111_0000});
    nxt(); load_data = 32'h1111_0001;
    sb.push_back({32'd4, 32'h1111_0001});
    nxt(); load_start = 1'b1; load_data = 32'hBAD0_BAD0;
    smp();
    chk("rs_ready", 64'(load_ready), 64'd0);
    nxt(); load_start = 1'b0; load_data = 32'h2222_0002; load_last = 1'b1;
    sb.push_back({32'd0, 32'h2222_0002});
    nxt(); load_valid = 1'b0; load_last = 1'b0;
    nxt();
    smp();
    chk("rs_words", 64'(words_loaded), 64'd1);
    chk("rs_fault", 64'(pc_fault), 64'd0);
    chk("rs_fetch0", 64'(cpu_instr), 64'h2222_0002);

    // Reload request coincident with a fault.
    nxt(); cpu_pc = 32'd6; load_start = 1'b1;
    smp();
    chk("lsf_instr", 64'(cpu_instr), 64'd0);
    nxt(); load_start = 1'b0; cpu_pc = 32'h0;
    smp();
    chk("lsf_fault", 64'(pc_fault), 64'd0);
    chk("lsf_corerst", 64'(core_reset), 64'd1);
    chk("lsf_ready", 64'(load_ready), 64'd1);
    chk("lsf_run", 64'(cpu_run), 64'd0);

    // Reset in the middle of a load.
    nxt(); load_valid = 1'b1; load_data = 32'h3333_0000;
    sb.push_back({32'd0, 32'h3333_0000});
    nxt(); load_data = 32'h3333_0001; reset = 1'b1;
    nxt(); reset = 1'b0;
    smp();
    chk("mrst_we", 64'(mem_we), 64'd0);
    chk("mrst_ready", 64'(load_ready), 64'd0);
    chk("mrst_corerst", 64'(core_reset), 64'd1);
    chk("mrst_words", 64'(words_loaded), 64'd0);
    chk("mrst_run", 64'(cpu_run), 64'd0);
    nxt(); load_valid = 1'b0;
    smp();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
